// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative MULT/MULTU/DIV/DIVU unit feeding HI/LO.
// Shift-add multiply and restoring divide on a shared 2W accumulator,
// one iteration per clock, with start/ready/valid handshake and cancel.
//
// Ports:
//   clk          system clock (rising edge)
//   rst_n        synchronous active-low reset
//   start        request, taken only while ready=1 and cancel=0
//   op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   x[W-1:0]     rs operand (multiplicand / dividend)
//   y[W-1:0]     rt operand (multiplier / divisor)
//   cancel       flush; aborts any operation in flight
//   ready        unit can accept start this cycle
//   result_valid one-cycle pulse when hi/lo have just been written
//   hi[W-1:0]    product upper half / remainder
//   lo[W-1:0]    product lower half / quotient
module alu_muldiv_iter #(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cancel,
    output logic         ready,
    output logic         result_valid,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic           r_is_div;
    logic           r_qsign;
    logic           r_rsign;
    logic           r_yzero;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;

    logic           w_accept;
    logic           w_x_neg;
    logic           w_y_neg;
    logic [W-1:0]   w_x_mag;
    logic [W-1:0]   w_y_mag;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]     w_shift;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_div_next;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_x_orig;

    assign ready        = (r_state == S_IDLE) || (r_state == S_DONE);
    assign result_valid = (r_state == S_DONE);
    assign hi           = r_hi;
    assign lo           = r_lo;

    assign w_accept = start && ready && !cancel;

    // op[0]=0 selects the signed variants
    assign w_x_neg = !op[0] && x[W-1];
    assign w_y_neg = !op[0] && y[W-1];
    assign w_x_mag = w_x_neg ? -x : x;
    assign w_y_mag = w_y_neg ? -y : y;

    // Multiply: multiplier sits in acc low half and is consumed LSB first
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]}
                      + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at LSB
    assign w_shift    = r_acc[2*W-1:W-1];
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_div_next = w_diff[W]
                      ? {w_shift[W-1:0], r_acc[W-2:0], 1'b0}
                      : {w_diff[W-1:0],  r_acc[W-2:0], 1'b1};

    assign w_prod = r_qsign ? -r_acc : r_acc;
    assign w_quo  = r_qsign ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem  = r_rsign ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
    // Rebuild the raw dividend from its magnitude for the y=0 case
    assign w_x_orig = r_rsign ? -r_a : r_a;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_yzero  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_qsign  <= w_x_neg ^ w_y_neg;
            r_rsign  <= w_x_neg;
            r_yzero  <= (y == '0);
            r_a      <= w_x_mag;
            r_b      <= w_y_mag;
            r_acc    <= op[1] ? {{W{1'b0}}, w_x_mag}
                              : {{W{1'b0}}, w_y_mag};
        end else begin
            case (r_state)
                S_RUN: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        if (r_cnt == CNT_W'(W - 1)) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                        if (!r_is_div) begin
                            r_hi <= w_prod[2*W-1:W];
                            r_lo <= w_prod[W-1:0];
                        end else if (r_yzero) begin
                            r_hi <= w_x_orig;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// tb_alu_muldiv_iter: directed table-driven bench for alu_muldiv_iter.
// Vector table for the arithmetic plus sequences for handshake corners.
module tb_alu_muldiv_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         ready;
    logic         result_valid;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    alu_muldiv_iter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .x(x), .y(y), .cancel(cancel), .ready(ready),
        .result_valid(result_valid), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(inout int n);
        do begin
            tick();
            n++;
        end while (!result_valid && n < 100);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        op = o;
        x = a;
        y = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic quiet(input string name, input int cyc);
        int cnt = 0;
        repeat (cyc) begin
            tick();
            if (result_valid) cnt++;
        end
        chk(name, cnt, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vt[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5"};
        vt[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, "multu_max"};
        vt[2]  = '{2'b00, 32'd7, 32'd6, 32'h0, 32'd42, "mult_7x6"};
        vt[3]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, "mult_m1xm1"};
        vt[4]  = '{2'b01, 32'h10000, 32'h10000, 32'h1, 32'h0, "multu_2p32"};
        vt[5]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, "mult_minxmin"};
        vt[6]  = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7"};
        vt[7]  = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
        vt[8]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, "div_7_m2"};
        vt[9]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, "div_m7_m2"};
        vt[10] = '{2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, "divu_by0"};
        vt[11] = '{2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_m7_by0"};
        vt[12] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_ovf"};
        vt[13] = '{2'b11, 32'hFFFFFFFF, 32'd2, 32'd1, 32'h7FFFFFFF, "divu_max_2"};
        vt[14] = '{2'b10, 32'h80000000, 32'd2, 32'h0, 32'hC0000000, "div_min_2"};

        // power-on reset
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_ready", {31'b0, ready}, 1);
        chk("rst_valid", {31'b0, result_valid}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            chk({vt[i].name, "_ready"}, {31'b0, ready}, 1);
            issue(vt[i].op, vt[i].x, vt[i].y);
            n = 0;
            wait_valid(n);
            chk({vt[i].name, "_lat"}, n, 33);
            chk({vt[i].name, "_hi"}, hi, vt[i].hi);
            chk({vt[i].name, "_lo"}, lo, vt[i].lo);
            tick();
            chk({vt[i].name, "_pulse"}, {31'b0, result_valid}, 0);
        end

        // start held while busy, operands changed mid-run
        op = 2'b11; x = 32'd100; y = 32'd7; start = 1'b1;
        tick();
        n = 0;
        x = 32'd1000; y = 32'd3; op = 2'b00;
        repeat (20) begin
            tick();
            n++;
        end
        chk("hold_early_valid", {31'b0, result_valid}, 0);
        start = 1'b0;
        wait_valid(n);
        chk("hold_lat", n, 33);
        chk("hold_hi", hi, 32'd2);
        chk("hold_lo", lo, 32'd14);
        quiet("hold_single", 40);

        // back-to-back issue from DONE
        issue(2'b01, 32'd3, 32'd4);
        n = 0;
        wait_valid(n);
        chk("b2b_first_lo", lo, 32'd12);
        chk("b2b_first_hi", hi, 32'd0);
        chk("b2b_done_ready", {31'b0, ready}, 1);
        issue(2'b11, 32'd100, 32'd7);
        n = 1;
        wait_valid(n);
        chk("b2b_gap", n, 34);
        chk("b2b_hi", hi, 32'd2);
        chk("b2b_lo", lo, 32'd14);
        tick();

        // cancel at iteration 10 of a DIV
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cxl_ready", {31'b0, ready}, 1);
        chk("cxl_valid", {31'b0, result_valid}, 0);
        chk("cxl_hi", hi, 32'd2);
        chk("cxl_lo", lo, 32'd14);
        quiet("cxl_quiet", 40);

        // new MULT right after the flush
        issue(2'b00, 32'hFFFFFFFD, 32'd5);
        n = 0;
        wait_valid(n);
        chk("post_cxl_lat", n, 33);
        chk("post_cxl_hi", hi, 32'hFFFFFFFF);
        chk("post_cxl_lo", lo, 32'hFFFFFFF1);

        // cancel in DONE: pulse stands, new start refused
        op = 2'b11; x = 32'd100; y = 32'd7;
        start = 1'b1; cancel = 1'b1;
        chk("done_cxl_valid", {31'b0, result_valid}, 1);
        tick();
        start = 1'b0; cancel = 1'b0;
        chk("done_cxl_ready", {31'b0, ready}, 1);
        quiet("done_cxl_quiet", 40);
        chk("done_cxl_lo", lo, 32'hFFFFFFF1);

        // cancel with start in IDLE
        start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        quiet("idle_cxl_quiet", 40);
        chk("idle_cxl_hi", hi, 32'hFFFFFFFF);

        // reset held two cycles mid-RUN
        issue(2'b01, 32'd3, 32'd4);
        repeat (5) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("mrst_ready", {31'b0, ready}, 1);
        chk("mrst_valid", {31'b0, result_valid}, 0);
        chk("mrst_hi", hi, 0);
        chk("mrst_lo", lo, 0);
        quiet("mrst_quiet", 40);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_iter.md
Name: alu_muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit; successor to the single-cycle combinational ALU.
- Executes MULT, MULTU, DIV and DIVU, which the single-cycle ALU cannot, using a shift-add / restoring-division datapath.
- Sits in EXE beside the ALU and feeds the HI/LO registers.
- Uses a start/ready/valid handshake so the pipeline stalls while busy; a cancel input supports exception flush.

Parameters:
- W, 32, operand width in bits. Products and remainders are W bits each (hi/lo); W ≥ 4.
- CNT_W, $clog2(W)+1, iteration counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  request; accepted only when ready=1.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- x  input  W  rs operand (multiplicand / dividend).
- y  input  W  rt operand (multiplier / divisor).
- cancel  input  1  flush; aborts any operation in flight.
- ready  output  1  unit can accept start this cycle.
- result_valid  output  1  one-cycle pulse; hi/lo are updated.
- hi  output  W  MULT: upper product half. DIV: remainder.
- lo  output  W  MULT: lower product half. DIV: quotient.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; ready=1; result_valid=0; hi=0; lo=0; counter=0. Reset overrides start and cancel, and takes effect even mid-operation.
- States:
  - IDLE: ready=1.
  - RUN: exactly W iterations, one per edge.
  - FIX: sign correction; results written to hi/lo.
  - DONE: result_valid=1, ready=1.
- Accept edge (start=1, ready=1, cancel=0):
  - latch op;
  - latch |x| and |y| for signed ops (two's-complement magnitudes), raw x and y for unsigned ops;
  - record sign flags: product sign = x[W-1]^y[W-1]; quotient sign = x^y sign; remainder sign = x[W-1];
  - counter=0; go to RUN.
- RUN:
  - Multiply: shift-add on a 2W accumulator.
  - Divide: restoring, one quotient bit per edge.
  - When counter reaches W-1, the next edge goes to FIX.
- FIX:
  - the edge writes signed-corrected results to hi/lo and goes to DONE;
  - the next edge leaves DONE: to RUN if start is accepted that edge, else to IDLE.
- Latency: result_valid goes high for exactly one cycle, W+1 edges after the accept edge. Back-to-back issue from DONE gives a W+2-cycle throughput.
- start while ready=0 is ignored (not queued). Inputs are sampled only on the accept edge; changes afterwards have no effect.
- hi/lo hold their value between completions; they change only on the FIX edge (or on reset).
- cancel=1 at any edge in RUN/FIX: go to IDLE, no result_valid, hi/lo unchanged.
  - cancel in DONE: result_valid for that cycle stands; no new accept.
  - cancel with start in IDLE: not accepted.
- Divide by zero (y=0), DIV or DIVU: lo = all ones, hi = x (original, unsigned-interpreted dividend), full latency.
- Signed overflow DIV (x = most-negative, y = −1): lo = most-negative value (0x80000000 for W=32), hi = 0.
- Signed DIV: remainder takes the sign of the dividend; the quotient truncates toward zero.
- MULT/MULTU: {hi,lo} is the exact 2W-bit product; no overflow is possible.

Test Plan:
- Reset with rst_n=0 held 2 cycles mid-RUN, then released → ready=1, result_valid=0, hi=lo=0, no spurious valid afterwards.
- MULT x=0xFFFFFFFD (−3), y=5 → valid exactly 33 edges after the accept edge; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 → lo=14, hi=2. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/−2 → lo=0xFFFFFFFD, hi=1.
- DIVU 0x1234/0 → lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Start held high while busy, with x/y changed mid-RUN → one result only, computed from the accept-edge operands. Start asserted in the DONE cycle → second op accepted; second valid arrives 34 edges after the first.
- Cancel at iteration 10 of a DIV → ready=1 next cycle, no result_valid, hi/lo keep the prior result. A new MULT issued immediately afterwards completes correctly.
